// File: rtl/dcm_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
// Contents: DEF_PROG_W (default programming width), DIV_W (divider width
// for the default programming width), div_term() (divider terminal value).
package dcm_pkg;

  localparam int unsigned DEF_PROG_W = 3;
  localparam int unsigned DIV_W      = (1 << DEF_PROG_W) - 1;

  // Terminal count of a channel divider running at exponent e: 2^e - 1.
  function automatic int unsigned div_term(input int unsigned e);
    return (32'd1 << e) - 32'd1;
  endfunction

endpackage

// File: rtl/dcm_slow_ch.sv
// One slow-clock channel: update edge detect, pending request, tick-driven
// divider and glitch-free reprogramming at the falling edge of clk_2.
// Ports:
//   clk, rst      reference clock, async active-low reset
//   tick_i        one-cycle pulse on every fast-clock toggle
//   update_i      update request level (rising edge captures prog_i)
//   prog_i        requested exponent
//   clk_2_o       slow clock, half period = 2^active ticks
//   prog_o        exponent currently generated
//   pend_o        a captured request is waiting to be applied
module dcm_slow_ch
  import dcm_pkg::*;
#(
  parameter int unsigned PROG_W  = DEF_PROG_W,
  parameter int unsigned DIV_W_P = DIV_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick_i,
  input  logic              update_i,
  input  logic [PROG_W-1:0] prog_i,
  output logic              clk_2_o,
  output logic [PROG_W-1:0] prog_o,
  output logic              pend_o
);

  logic               upd_q,     upd_d;
  logic               pend_q,    pend_d;
  logic [PROG_W-1:0]  pending_q, pending_d;
  logic [PROG_W-1:0]  active_q,  active_d;
  logic [DIV_W_P-1:0] div_q,     div_d;
  logic               clk2_q,    clk2_d;

  logic               rise_c;
  logic [DIV_W_P-1:0] term_c;
  logic               at_term_c;

  // Next-state: divider advance, apply on the 1->0 toggle, then capture.
  always_comb begin
    upd_d     = update_i;
    pend_d    = pend_q;
    pending_d = pending_q;
    active_d  = active_q;
    div_d     = div_q;
    clk2_d    = clk2_q;

    rise_c    = update_i & ~upd_q;
    term_c    = DIV_W_P'(div_term(32'(active_q)));
    at_term_c = (div_q == term_c);

    if (tick_i) begin
      if (at_term_c) begin
        clk2_d = ~clk2_q;
        div_d  = '0;
        // Switching only as the clock falls keeps every half period whole.
        if (clk2_q && pend_q) begin
          active_d = pending_q;
          pend_d   = 1'b0;
        end
      end else begin
        div_d = div_q + DIV_W_P'(1);
      end
    end

    // Capture after apply so a coincident rise becomes the next pending value.
    if (rise_c) begin
      pending_d = prog_i;
      pend_d    = 1'b1;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      upd_q     <= 1'b0;
      pend_q    <= 1'b0;
      pending_q <= '0;
      active_q  <= '0;
      div_q     <= '0;
      clk2_q    <= 1'b0;
    end else begin
      upd_q     <= upd_d;
      pend_q    <= pend_d;
      pending_q <= pending_d;
      active_q  <= active_d;
      div_q     <= div_d;
      clk2_q    <= clk2_d;
    end
  end

  assign clk_2_o = clk2_q;
  assign prog_o  = active_q;
  assign pend_o  = pend_q;

endmodule

// File: rtl/dcm_multi.sv
// Fast clock generator plus N_CH independently programmable slow clocks,
// all derived from one reference clock and phase-aligned to clk_1.
// Ports:
//   clk       reference clock
//   rst       async active-low reset
//   update    per-channel update request (rising edge significant)
//   prog_in   per-channel requested exponent, channel i at [i*PROG_W +: PROG_W]
//   clk_1     fast clock, period 2*HALF_COUNT clk cycles
//   clk_2     per-channel slow clock, period 2*HALF_COUNT*2^prog clk cycles
//   prog_out  exponent each channel is currently generating
//   pend      per-channel request-pending flag
module dcm_multi
  import dcm_pkg::*;
#(
  parameter int unsigned HALF_COUNT = 5000000,
  parameter int unsigned N_CH       = 2,
  parameter int unsigned PROG_W     = DEF_PROG_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH-1:0]          update,
  input  logic [N_CH*PROG_W-1:0]   prog_in,
  output logic                     clk_1,
  output logic [N_CH-1:0]          clk_2,
  output logic [N_CH*PROG_W-1:0]   prog_out,
  output logic [N_CH-1:0]          pend
);

  localparam int unsigned CNT_W    = (HALF_COUNT > 1) ? $clog2(HALF_COUNT) : 1;
  localparam int unsigned CH_DIV_W = (1 << PROG_W) - 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clk1_q, clk1_d;
  logic             tick_c;

  // Fast counter wraps at HALF_COUNT-1; the wrap is the shared tick.
  always_comb begin
    cnt_d  = cnt_q + CNT_W'(1);
    clk1_d = clk1_q;
    tick_c = (cnt_q == CNT_W'(HALF_COUNT - 1));
    if (tick_c) begin
      cnt_d  = '0;
      clk1_d = ~clk1_q;
    end
  end

  // Fast counter and clk_1 registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      clk1_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      clk1_q <= clk1_d;
    end
  end

  assign clk_1 = clk1_q;

  // One divider channel per slow clock; they share only the tick.
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    dcm_slow_ch #(
      .PROG_W  (PROG_W),
      .DIV_W_P (CH_DIV_W)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .tick_i   (tick_c),
      .update_i (update[i]),
      .prog_i   (prog_in[i*PROG_W +: PROG_W]),
      .clk_2_o  (clk_2[i]),
      .prog_o   (prog_out[i*PROG_W +: PROG_W]),
      .pend_o   (pend[i])
    );
  end

endmodule

// File: tb/tb_dcm_multi.sv
// Self-checking bench for dcm_multi (HALF_COUNT=4, N_CH=2, PROG_W=3).
// Reference model: slow clocks expressed as a function of elapsed fast ticks
// since the last reprogramming point.
module tb_dcm_multi;

  localparam int HC = 4;
  localparam int NCH = 2;
  localparam int PW = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] update;
  logic [5:0] prog_in;
  logic       clk_1;
  logic [1:0] clk_2;
  logic [5:0] prog_out;
  logic [1:0] pend;

  dcm_multi #(.HALF_COUNT(HC), .N_CH(NCH), .PROG_W(PW)) dut (
    .clk      (clk),
    .rst      (rst),
    .update   (update),
    .prog_in  (prog_in),
    .clk_1    (clk_1),
    .clk_2    (clk_2),
    .prog_out (prog_out),
    .pend     (pend)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: edges since release, ticks elapsed, per-channel segment start.
  int m_edges;
  int m_k;
  int m_active [2];
  int m_pending[2];
  int m_k0     [2];
  bit m_pend   [2];
  bit m_prev   [2];

  typedef struct {
    logic [1:0] upd;
    logic [5:0] prog;
    int         hold;
    logic [5:0] exp_po;
    logic [1:0] exp_pend;
  } vec_t;

  vec_t vt[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_edges = 0;
    m_k = 0;
    for (int c = 0; c < 2; c++) begin
      m_active[c] = 0; m_pending[c] = 0; m_k0[c] = 0;
      m_pend[c] = 1'b0; m_prev[c] = 1'b0;
    end
  endtask

  task automatic model_step();
    bit tick;
    bit rise;
    m_edges++;
    tick = (m_edges % HC) == 0;
    if (tick) m_k++;
    for (int c = 0; c < 2; c++) begin
      rise = update[c] && !m_prev[c];
      m_prev[c] = update[c];
      // Reprogram only when a full slow period has elapsed (clock falls).
      if (tick && m_pend[c] && ((m_k - m_k0[c]) % (2 << m_active[c])) == 0) begin
        m_active[c] = m_pending[c];
        m_k0[c] = m_k;
        m_pend[c] = 1'b0;
      end
      if (rise) begin
        m_pending[c] = int'(prog_in[c*PW +: PW]);
        m_pend[c] = 1'b1;
      end
    end
  endtask

  task automatic check_model();
    logic [1:0] e_c2;
    logic [5:0] e_po;
    logic [1:0] e_pd;
    for (int c = 0; c < 2; c++) begin
      e_c2[c] = ((m_k - m_k0[c]) >> m_active[c]) & 1;
      e_po[c*PW +: PW] = 3'(m_active[c]);
      e_pd[c] = m_pend[c];
    end
    chk("model_clk_1", 32'(clk_1), 32'(m_k & 1));
    chk("model_clk_2", 32'(clk_2), 32'(e_c2));
    chk("model_prog_out", 32'(prog_out), 32'(e_po));
    chk("model_pend", 32'(pend), 32'(e_pd));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    update = 2'b00;
    prog_in = 6'd0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    chk("reset_state", {clk_1, clk_2, prog_out, pend}, 32'd0);
  endtask

  task automatic first_rise_check();
    int found;
    found = 0;
    for (int i = 1; i <= 20; i++) begin
      cycle();
      if (clk_1 === 1'b1) begin
        found = i;
        break;
      end
    end
    chk("first_clk_1_rise_cycle", 32'(found), 32'd4);
  endtask

  task automatic wait_c2(input int ch, input logic lvl, input int maxc, output int n);
    n = 0;
    while (clk_2[ch] !== lvl && n < maxc) begin
      cycle();
      n++;
    end
    chk("wait_clk_2_level", 32'(clk_2[ch] === lvl), 32'd1);
  endtask

  initial begin
    int w, n_hi, n_lo, n_tmp;

    // Directed table: {update, prog_in, hold cycles, prog_out, pend}.
    vt[0]  = '{2'b00, 6'd0,  4,   6'd0,  2'b00};
    vt[1]  = '{2'b01, 6'd2,  1,   6'd0,  2'b01};
    vt[2]  = '{2'b00, 6'd0,  6,   6'd0,  2'b01};
    vt[3]  = '{2'b00, 6'd0,  1,   6'd2,  2'b00};
    vt[4]  = '{2'b01, 6'd1,  1,   6'd2,  2'b01};
    vt[5]  = '{2'b00, 6'd0,  30,  6'd2,  2'b01};
    vt[6]  = '{2'b01, 6'd4,  1,   6'd1,  2'b01};
    vt[7]  = '{2'b00, 6'd0,  15,  6'd1,  2'b01};
    vt[8]  = '{2'b00, 6'd0,  1,   6'd4,  2'b00};
    vt[9]  = '{2'b10, 6'd24, 20,  6'd28, 2'b00};
    vt[10] = '{2'b00, 6'd24, 1,   6'd28, 2'b00};
    vt[11] = '{2'b10, 6'd8,  1,   6'd28, 2'b10};
    vt[12] = '{2'b01, 6'd3,  1,   6'd28, 2'b11};
    vt[13] = '{2'b00, 6'd0,  1,   6'd28, 2'b11};
    vt[14] = '{2'b01, 6'd5,  1,   6'd28, 2'b11};
    vt[15] = '{2'b00, 6'd0,  103, 6'd13, 2'b00};

    do_reset();
    first_rise_check();

    foreach (vt[j]) begin
      update  = vt[j].upd;
      prog_in = vt[j].prog;
      repeat (vt[j].hold) cycle();
      chk($sformatf("vec%0d_prog_out", j), 32'(prog_out), 32'(vt[j].exp_po));
      chk($sformatf("vec%0d_pend", j), 32'(pend), 32'(vt[j].exp_pend));
    end

    // Random update traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) update[0] = ~update[0];
      if ($urandom_range(0, 15) == 0) update[1] = ~update[1];
      prog_in = 6'($urandom);
      cycle();
    end

    // Channel 1 at exponent 7: 512-cycle high, 1024-cycle period.
    update = 2'b00;
    cycle();
    prog_in = 6'd56;
    update = 2'b10;
    cycle();
    update = 2'b00;
    w = 0;
    while (prog_out[5:3] !== 3'd7 && w < 2200) begin
      cycle();
      w++;
    end
    chk("ch1_prog7_applied", 32'(prog_out[5:3]), 32'd7);
    wait_c2(1, 1'b1, 1100, n_tmp);
    wait_c2(1, 1'b0, 1100, n_hi);
    wait_c2(1, 1'b1, 1100, n_lo);
    chk("ch1_high_time", 32'(n_hi), 32'd512);
    chk("ch1_period", 32'(n_hi + n_lo), 32'd1024);

    // Leave a request pending, then reset mid-period.
    repeat (100) cycle();
    prog_in = 6'd5;
    update = 2'b01;
    cycle();
    update = 2'b00;
    cycle();
    chk("pend_before_reset", 32'(pend[0]), 32'd1);
    #1;
    rst = 1'b0;
    #1;
    chk("async_reset_clk_1", 32'(clk_1), 32'd0);
    chk("async_reset_clk_2", 32'(clk_2), 32'd0);
    chk("async_reset_prog_out", 32'(prog_out), 32'd0);
    chk("async_reset_pend", 32'(pend), 32'd0);
    do_reset();
    first_rise_check();
    repeat (60) cycle();
    chk("post_reset_prog_out", 32'(prog_out), 32'd0);
    chk("post_reset_pend", 32'(pend), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
